// File: rtl/cla_sub_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cla_sub_seq_if
// Brief    : Operand/result handshake bundle for cla_sub_seq. The ovf signal
//            exists only when CLA_SUB_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface cla_sub_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;
`ifdef CLA_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow_out, zero
`ifdef CLA_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow_out, zero
`ifdef CLA_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/cla_sub_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cla_sub_seq
// Brief    : Nibble-serial A - B - bin using a 4-bit carry-lookahead slice per
//            cycle, valid/ready on both sides. CLA_SUB_OVF_EN adds signed ovf.
// Revision : 1.0 - initial release
// ============================================================================
module cla_sub_seq #(
    parameter int NIBBLES = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    cla_sub_seq_if.slave  bus
);
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CW-1:0]            r_cnt;
    logic [NIBBLES-1:0][3:0]  r_a;
    logic [NIBBLES-1:0][3:0]  r_b;
    logic [NIBBLES-1:0][3:0]  r_diff;
    logic                     r_carry;
    logic                     r_borrow;
    logic                     r_zero;
    logic [3:0]               w_p;
    logic [3:0]               w_g;
    logic [4:0]               w_c;
    logic [3:0]               w_sum;
    logic [NIBBLES-1:0][3:0]  w_diff_full;
    logic                     w_last;
    logic                     w_accept;
`ifdef CLA_SUB_OVF_EN
    logic                     r_ovf;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    assign w_last = (r_cnt == CW'(NIBBLES - 1));

    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Subtraction as A + ~B + ~bin: the carry register holds the inverted borrow.
    always_comb begin
        w_p    = r_a[r_cnt] ^ ~r_b[r_cnt];
        w_g    = r_a[r_cnt] & ~r_b[r_cnt];
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_sum  = w_p ^ w_c[3:0];
        w_diff_full        = r_diff;
        w_diff_full[r_cnt] = w_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= ~bus.bin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_diff  <= w_diff_full;
                    r_carry <= w_c[4];
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_borrow <= ~w_c[4];
                        r_zero   <= (w_diff_full == '0);
`ifdef CLA_SUB_OVF_EN
                        r_ovf    <= (r_a[NIBBLES-1][3] != r_b[NIBBLES-1][3])
                                  & (w_sum[3] != r_a[NIBBLES-1][3]);
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow;
    assign bus.zero       = r_zero;
`ifdef CLA_SUB_OVF_EN
    assign bus.ovf        = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_sub_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cla_sub_seq
// Brief    : Scoreboard bench for cla_sub_seq: directed cases, backpressure,
//            mid-run reset and randomized operands against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_sub_seq;
    localparam int NIBBLES = 4;
    localparam int WIDTH   = 4 * NIBBLES;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
        logic             ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks     = 0;
    int   failures   = 0;
    int   ready_mode = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t bp_e;

    always #5 clk = ~clk;

    cla_sub_seq_if #(.NIBBLES(NIBBLES)) bus ();
    cla_sub_seq #(.NIBBLES(NIBBLES)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin);
        exp_t e;
        int   r;
        r        = int'(a) - int'(b) - int'(bin);
        e.diff   = r[WIDTH-1:0];
        e.borrow = (r < 0);
        e.zero   = (e.diff == 0);
        e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Consumer-side ready: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got diff=0x%0h with no pending op", bus.diff);
                end else begin
                    mon_e = sb.pop_front();
                    chk("diff", bus.diff, mon_e.diff);
                    chk("borrow_out", bus.borrow_out, mon_e.borrow);
                    chk("zero", bus.zero, mon_e.zero);
`ifdef CLA_SUB_OVF_EN
                    chk("ovf", bus.ovf, mon_e.ovf);
`endif
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        int n = 0;
        bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        sb.push_back(model(a, b, bin));
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 40);
        chk("latency", lat, NIBBLES);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        issue(a, b, bin);
        wait_valid();
        wait_drain();
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int n;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_borrow", bus.borrow_out, 0);
        chk("rst_zero", bus.zero, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_op(16'h1234, 16'h0235, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1);
        run_op(16'hBEEF, 16'hBEEF, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0);

        // Backpressure: result must hold and a new request must be ignored
        ready_mode = 2;
        @(posedge clk); #2;
        bp_e = model(16'h1234, 16'h0235, 1'b0);
        issue(16'h1234, 16'h0235, 1'b0);
        wait_valid();
        bus.a = 16'hFFFF; bus.b = 16'h0000; bus.bin = 1'b0; bus.in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_diff", bus.diff, bp_e.diff);
            chk("bp_borrow", bus.borrow_out, bp_e.borrow);
            chk("bp_zero", bus.zero, bp_e.zero);
        end
        bus.in_valid = 1'b0;
        ready_mode = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.out_valid && n < 10);
        chk("bp_in_ready_after", bus.in_ready, 1);
        chk("bp_popped", sb.size(), 0);
        wait_drain();

        // Reset two cycles into RUN abandons the operation
        issue(16'h1234, 16'h0001, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_diff", bus.diff, 0);
        chk("mid_rst_borrow", bus.borrow_out, 0);
        chk("mid_rst_zero", bus.zero, 0);
        void'(sb.pop_back());
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", bus.out_valid, 0);
        end
        run_op(16'h0010, 16'h0001, 1'b0);

        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 5 == 0) ? ra : WIDTH'($urandom);
            issue(ra, rb, 1'($urandom_range(0, 1)));
            wait_valid();
        end
        ready_mode = 0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
